// File: rtl/reduce_gate_pipe.sv
// reduce_gate_pipe: per-lane AND/NAND/OR/NOR/XOR/XNOR reduction, pipelined with valid/ready backpressure.
// Stage 1 reduces bit groups, later stages combine pairs of partials, inversion and reserved masking at the output.
module reduce_gate_pipe #(
  parameter int WIDTH       = 4,
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES*WIDTH-1:0] i_data,
  input  logic [2:0]             i_mode,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [LANES-1:0]       o_f,
  output logic                   o_err
);
  localparam int NG = 1 << (PIPE_STAGES - 1);
  localparam int G  = (WIDTH + NG - 1) / NG;
  localparam int PW = LANES * NG;
  logic [PIPE_STAGES:1] v;
  logic [PIPE_STAGES:1] ld;
  logic [PIPE_STAGES:1] vin;
  logic [2:0]           m    [1:PIPE_STAGES];
  logic [2:0]           min  [1:PIPE_STAGES];
  logic [PW-1:0]        q    [1:PIPE_STAGES];
  logic [PW-1:0]        nxt  [1:PIPE_STAGES];
  function automatic logic op2(input logic a, input logic b, input logic [1:0] op);
    return op == 2'd0 ? a & b : op == 2'd1 ? a | b : a ^ b;
  endfunction
  // Ready ripples back from the output so a full pipe still moves when downstream takes a beat.
  always_comb begin
    logic r;
    r  = i_ready;
    ld = '0;
    for (int k = PIPE_STAGES; k >= 1; k--) begin
      r     = ~v[k] | r;
      ld[k] = r;
    end
  end
  always_comb begin
    logic acc;
    int   idx;
    acc = 1'b0;
    idx = 0;
    for (int k = 1; k <= PIPE_STAGES; k++) begin
      nxt[k] = '0;
      vin[k] = k == 1 ? i_valid : v[k == 1 ? 1 : k - 1];
      min[k] = k == 1 ? i_mode : m[k == 1 ? 1 : k - 1];
    end
    for (int n = 0; n < LANES; n++)
      for (int g = 0; g < NG; g++) begin
        acc = i_mode[2:1] == 2'd0;
        for (int j = 0; j < G; j++) begin
          idx = g * G + j;
          if (idx < WIDTH) acc = op2(acc, i_data[n * WIDTH + idx], i_mode[2:1]);
        end
        nxt[1][n * NG + g] = acc;
      end
    for (int k = 2; k <= PIPE_STAGES; k++)
      for (int n = 0; n < LANES; n++)
        for (int j = 0; j < (NG >> (k - 1)); j++)
          nxt[k][n * NG + j] = op2(q[k - 1][n * NG + 2 * j], q[k - 1][n * NG + 2 * j + 1], m[k - 1][2:1]);
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      v <= '0;
      for (int k = 1; k <= PIPE_STAGES; k++) begin
        m[k] <= '0;
        q[k] <= '0;
      end
    end else
      for (int k = 1; k <= PIPE_STAGES; k++)
        if (ld[k]) begin
          v[k] <= vin[k];
          if (vin[k]) begin
            m[k] <= min[k];
            q[k] <= nxt[k];
          end
        end
  assign o_valid = v[PIPE_STAGES];
  assign o_ready = ld[1];
  assign o_err   = &m[PIPE_STAGES][2:1];
  always_comb
    for (int n = 0; n < LANES; n++) o_f[n] = o_err ? 1'b0 : q[PIPE_STAGES][n * NG] ^ m[PIPE_STAGES][0];
endmodule

// File: tb/tb_reduce_gate_pipe.sv
// tb_reduce_gate_pipe: directed scenarios on a default instance plus a reference-model sweep over PIPE_STAGES 1..4.
module tb_reduce_gate_pipe;
  logic       clk = 1'b0;
  logic       rst_n, valid, ready, o_ready, o_valid, o_err;
  logic [3:0] data;
  logic [2:0] mode;
  logic [0:0] f;
  logic       gv, gr;
  logic [2:0] gm;
  logic [26:0] gd;
  logic [3:0] g_rdy, g_vld, g_err;
  logic [2:0] g_f [4];
  logic [3:0] sb [4][16];
  int         wp [4];
  int         rp [4];
  int         tests = 0;
  int         fails = 0;
  always #5 clk = ~clk;
  reduce_gate_pipe dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(o_ready), .i_data(data),
    .i_mode(mode), .o_valid(o_valid), .i_ready(ready), .o_f(f), .o_err(o_err)
  );
  for (genvar i = 0; i < 4; i++) begin : g_inst
    reduce_gate_pipe #(.WIDTH(9), .LANES(3), .PIPE_STAGES(i + 1)) u (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(gv), .o_ready(g_rdy[i]), .i_data(gd),
      .i_mode(gm), .o_valid(g_vld[i]), .i_ready(gr), .o_f(g_f[i]), .o_err(g_err[i])
    );
  end
  function automatic logic [3:0] ref_f(input logic [26:0] d, input logic [2:0] md);
    logic [2:0] r;
    logic [8:0] w;
    r = '0;
    if (md >= 3'd6) return 4'b1000;
    for (int n = 0; n < 3; n++) begin
      w = d[n * 9 +: 9];
      r[n] = (md[2:1] == 2'd0 ? &w : md[2:1] == 2'd1 ? |w : ^w) ^ md[0];
    end
    return {1'b0, r};
  endfunction
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; valid = 0; ready = 1; data = '0; mode = '0;
    gv = 0; gr = 1; gd = '0; gm = '0;
    step();
    step();
    tests++; if ({o_valid, o_ready, f, o_err} !== 4'b0100) begin fails++; $display("FAIL reset_dut: got %b want 0100", {o_valid, o_ready, f, o_err}); end
    tests++; if ({g_vld, g_rdy, g_err} !== 12'h0F0) begin fails++; $display("FAIL reset_gen: got %h want 0f0", {g_vld, g_rdy, g_err}); end
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_nand;
    valid = 1; mode = 3'd1; data = 4'hF; ready = 1;
    step();
    data = 4'h7;
    step();
    tests++; if ({o_valid, f} !== 2'b10) begin fails++; $display("FAIL nand_f: got %b want 10", {o_valid, f}); end
    valid = 0;
    step();
    tests++; if ({o_valid, f} !== 2'b11) begin fails++; $display("FAIL nand_7: got %b want 11", {o_valid, f}); end
    step();
    tests++; if ({o_valid, f} !== 2'b01) begin fails++; $display("FAIL nand_hold: got %b want 01", {o_valid, f}); end
  endtask
  task automatic test_xor_lanes;
    gd = {9'h101, 9'h000, 9'h1FF}; gm = 3'd4; gv = 1; gr = 1;
    step();
    gm = 3'd5;
    step();
    tests++; if ({g_vld[1], g_f[1]} !== 4'b1001) begin fails++; $display("FAIL xor_lanes: got %b want 1001", {g_vld[1], g_f[1]}); end
    gv = 0;
    step();
    tests++; if ({g_vld[1], g_f[1]} !== 4'b1110) begin fails++; $display("FAIL xnor_lanes: got %b want 1110", {g_vld[1], g_f[1]}); end
    repeat (4) step();
  endtask
  task automatic test_backpressure;
    logic [5:0] pat;
    logic [5:0] got;
    logic       acc;
    int         k, n;
    pat = 6'b011001; got = '0; k = 0; n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      valid = k < 6;
      data  = (k < 6 && pat[k]) ? 4'h1 : 4'h3;
      mode  = 3'd4;
      ready = c >= 6;
      #1;
      if (c == 5) begin
        tests++; if ({o_ready, o_valid, f} !== {2'b01, pat[0]}) begin fails++; $display("FAIL stall_state: got %b want %b", {o_ready, o_valid, f}, {2'b01, pat[0]}); end
        tests++; if (k !== 2) begin fails++; $display("FAIL stall_accepts: got %0d want 2", k); end
      end
      acc = valid & o_ready;
      if (o_valid & ready) begin
        got[n] = f[0];
        n++;
      end
      step();
      if (acc) k++;
    end
    tests++; if (n !== 6) begin fails++; $display("FAIL bp_count: got %0d want 6", n); end
    tests++; if (got !== pat) begin fails++; $display("FAIL bp_order: got %b want %b", got, pat); end
    valid = 0; ready = 1;
    repeat (3) step();
  endtask
  task automatic test_reserved;
    valid = 1; ready = 1; mode = 3'd2; data = 4'h2;
    step();
    mode = 3'd6; data = 4'hF;
    step();
    tests++; if ({o_valid, f, o_err} !== 3'b110) begin fails++; $display("FAIL rsv_pre: got %b want 110", {o_valid, f, o_err}); end
    mode = 3'd2; data = 4'h8;
    step();
    tests++; if ({o_valid, f, o_err} !== 3'b101) begin fails++; $display("FAIL rsv_mid: got %b want 101", {o_valid, f, o_err}); end
    valid = 0;
    step();
    tests++; if ({o_valid, f, o_err} !== 3'b110) begin fails++; $display("FAIL rsv_post: got %b want 110", {o_valid, f, o_err}); end
    step();
  endtask
  task automatic test_reset_mid;
    valid = 1; ready = 1; mode = 3'd1; data = 4'h0;
    step();
    step();
    tests++; if ({o_valid, f} !== 2'b11) begin fails++; $display("FAIL inflight: got %b want 11", {o_valid, f}); end
    rst_n = 0; valid = 0;
    #1;
    tests++; if ({o_valid, o_ready, f, o_err} !== 4'b0100) begin fails++; $display("FAIL rst_mid: got %b want 0100", {o_valid, o_ready, f, o_err}); end
    #2;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_stale: got %b want 0", o_valid); end
    end
  endtask
  task automatic test_random;
    logic [3:0] e;
    rst_n = 0;
    #2;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin wp[i] = 0; rp[i] = 0; end
    step();
    for (int c = 0; c < 6020; c++) begin
      gv = c < 6000 && $urandom_range(0, 3) != 0;
      gr = c >= 6000 || $urandom_range(0, 3) != 0;
      gm = 3'($urandom_range(0, 7));
      for (int n = 0; n < 3; n++)
        case ($urandom_range(0, 3))
          0:       gd[n * 9 +: 9] = 9'h000;
          1:       gd[n * 9 +: 9] = 9'h1FF;
          default: gd[n * 9 +: 9] = 9'($urandom);
        endcase
      #1;
      for (int i = 0; i < 4; i++) begin
        if (g_vld[i] & gr) begin
          e = sb[i][rp[i] % 16];
          tests++;
          if (rp[i] >= wp[i] || {g_err[i], g_f[i]} !== e) begin
            fails++;
            $display("FAIL rand_p%0d beat %0d: got %b want %b (queued %0d)", i + 1, rp[i], {g_err[i], g_f[i]}, e, wp[i] - rp[i]);
          end
          rp[i]++;
        end
        if (gv & g_rdy[i]) begin
          sb[i][wp[i] % 16] = ref_f(gd, gm);
          wp[i]++;
        end
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      tests++; if (rp[i] !== wp[i]) begin fails++; $display("FAIL rand_drain_p%0d: got %0d out want %0d", i + 1, rp[i], wp[i]); end
    end
  endtask
  initial begin
    test_reset();
    test_nand();
    test_xor_lanes();
    test_backpressure();
    test_reserved();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
